// File: rtl/core_ex_trap_ctrl_if.sv
// Redirect handshake between the trap controller and the pipeline.
// The controller drives the request and target; the pipeline acknowledges.
interface core_ex_trap_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  logic                flush_req;
  logic [PC_WIDTH-1:0] flush_pc;
  logic                flush_ack;

  modport master (
    output flush_req,
    output flush_pc,
    input  flush_ack
  );

  modport slave (
    input  flush_req,
    input  flush_pc,
    output flush_ack
  );
endinterface

// File: rtl/core_ex_trap_ctrl.sv
// Machine-mode trap controller: trap CSRs, cause priority, mret,
// direct/vectored redirect and a registered flush request held until ack.
module core_ex_trap_ctrl #(
  parameter int               XLEN         = 32,
  parameter int               PC_WIDTH     = 32,
  parameter int               NUM_PLAT_IRQ = 0,
  parameter bit               VECTORED_EN  = 1'b1,
  parameter logic [XLEN-1:0]  MTVEC_RESET  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmt_valid,
  input  logic [PC_WIDTH-1:0] cmt_pc,
  input  logic [31:0]         cmt_instr,
  input  logic                excp_ecall,
  input  logic                excp_ebreak,
  input  logic                excp_illegal,
  input  logic                excp_ld_misalign,
  input  logic                excp_st_misalign,
  input  logic                excp_mret,
  input  logic [XLEN-1:0]     excp_badaddr,
  input  logic [2:0]          irq_pending,
  input  logic [(NUM_PLAT_IRQ > 0 ? NUM_PLAT_IRQ : 1)-1:0]
                              plat_irq_pending,
  input  logic                csr_wr_en,
  input  logic [11:0]         csr_addr,
  input  logic [XLEN-1:0]     csr_wdata,
  output logic [XLEN-1:0]     csr_rdata,
  output logic                csr_hit,
  core_ex_trap_ctrl_if.master flush_if,
  output logic                trap_busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;

  function automatic logic [XLEN-1:0] irq_mask();
    logic [XLEN-1:0] m;
    m     = '0;
    m[3]  = 1'b1;
    m[7]  = 1'b1;
    m[11] = 1'b1;
    for (int i = 0; i < NUM_PLAT_IRQ; i++) m[16+i] = 1'b1;
    return m;
  endfunction

  localparam logic [XLEN-1:0] MIE_MASK = irq_mask();

  logic [0:0]          state_q, state_d;
  logic                st_mie_q, st_mie_d;
  logic                st_mpie_q, st_mpie_d;
  logic [XLEN-1:0]     mie_q, mie_d;
  logic [XLEN-3:0]     tvec_base_q, tvec_base_d;
  logic                tvec_mode_q, tvec_mode_d;
  logic [XLEN-1:0]     mscratch_q, mscratch_d;
  logic [XLEN-1:0]     mepc_q, mepc_d;
  logic [XLEN-1:0]     mcause_q, mcause_d;
  logic [XLEN-1:0]     mtval_q, mtval_d;
  logic [PC_WIDTH-1:0] fpc_q, fpc_d;

  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] irq_en;
  logic            plat_hit;
  logic [4:0]      plat_code;
  logic            take_trap;
  logic            take_mret;
  logic            is_irq;
  logic [4:0]      code;
  logic [XLEN-1:0] tval;
  logic [XLEN-1:0] trap_tgt;
  logic            unused_ok;

  always_comb begin
    mip     = '0;
    mip[3]  = irq_pending[0];
    mip[7]  = irq_pending[1];
    mip[11] = irq_pending[2];
    for (int i = 0; i < NUM_PLAT_IRQ; i++)
      mip[16+i] = plat_irq_pending[i];
  end

  assign irq_en = mip & mie_q & {XLEN{st_mie_q}};
  assign unused_ok = ^{plat_irq_pending, irq_en};

  // Scan downwards so the lowest-numbered pending line wins.
  always_comb begin
    plat_hit  = 1'b0;
    plat_code = 5'd0;
    for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
      if (irq_en[16+i]) begin
        plat_hit  = 1'b1;
        plat_code = 5'd16 + 5'(i);
      end
    end
  end

  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    is_irq    = 1'b0;
    code      = 5'd0;
    tval      = '0;
    if (state_q == S_IDLE && cmt_valid) begin
      take_trap = 1'b1;
      if (irq_en[11]) begin
        is_irq = 1'b1;
        code   = 5'd11;
      end else if (irq_en[3]) begin
        is_irq = 1'b1;
        code   = 5'd3;
      end else if (irq_en[7]) begin
        is_irq = 1'b1;
        code   = 5'd7;
      end else if (plat_hit) begin
        is_irq = 1'b1;
        code   = plat_code;
      end else if (excp_illegal) begin
        code = 5'd2;
        tval = XLEN'(cmt_instr);
      end else if (excp_ebreak) begin
        code = 5'd3;
        tval = XLEN'(cmt_pc);
      end else if (excp_ecall) begin
        code = 5'd11;
      end else if (excp_ld_misalign) begin
        code = 5'd4;
        tval = excp_badaddr;
      end else if (excp_st_misalign) begin
        code = 5'd6;
        tval = excp_badaddr;
      end else begin
        take_trap = 1'b0;
        take_mret = excp_mret;
      end
    end
  end

  assign trap_tgt = {tvec_base_q, 2'b00}
                  + ((tvec_mode_q && is_irq)
                     ? {{(XLEN-7){1'b0}}, code, 2'b00}
                     : '0);

  always_comb begin
    state_d     = state_q;
    st_mie_d    = st_mie_q;
    st_mpie_d   = st_mpie_q;
    mie_d       = mie_q;
    tvec_base_d = tvec_base_q;
    tvec_mode_d = tvec_mode_q;
    mscratch_d  = mscratch_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mtval_d     = mtval_q;
    fpc_d       = fpc_q;
    // A write racing a trap or mret is dropped so trap state stays coherent.
    if (csr_wr_en && !(take_trap || take_mret)) begin
      unique case (csr_addr)
        A_MSTATUS: begin
          st_mie_d  = csr_wdata[3];
          st_mpie_d = csr_wdata[7];
        end
        A_MIE:      mie_d = csr_wdata & MIE_MASK;
        A_MTVEC: begin
          tvec_base_d = csr_wdata[XLEN-1:2];
          tvec_mode_d = VECTORED_EN && (csr_wdata[1:0] == 2'b01);
        end
        A_MSCRATCH: mscratch_d = csr_wdata;
        A_MEPC:     mepc_d = {csr_wdata[XLEN-1:2], 2'b00};
        A_MCAUSE:   mcause_d = csr_wdata;
        A_MTVAL:    mtval_d = csr_wdata;
        default: ;
      endcase
    end
    if (take_trap) begin
      mepc_d    = {XLEN'(cmt_pc) >> 2, 2'b00};
      mcause_d  = {is_irq, (XLEN-1)'(code)};
      mtval_d   = tval;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
      fpc_d     = PC_WIDTH'(trap_tgt);
      state_d   = S_REQ;
    end else if (take_mret) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
      fpc_d     = PC_WIDTH'(mepc_q);
      state_d   = S_REQ;
    end
    if (state_q == S_REQ && flush_if.flush_ack) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      st_mie_q    <= 1'b0;
      st_mpie_q   <= 1'b0;
      mie_q       <= '0;
      tvec_base_q <= MTVEC_RESET[XLEN-1:2];
      tvec_mode_q <= VECTORED_EN && (MTVEC_RESET[1:0] == 2'b01);
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      fpc_q       <= '0;
    end else begin
      state_q     <= state_d;
      st_mie_q    <= st_mie_d;
      st_mpie_q   <= st_mpie_d;
      mie_q       <= mie_d;
      tvec_base_q <= tvec_base_d;
      tvec_mode_q <= tvec_mode_d;
      mscratch_q  <= mscratch_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
      fpc_q       <= fpc_d;
    end
  end

  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b1;
    unique case (csr_addr)
      A_MSTATUS: begin
        csr_rdata[12:11] = 2'b11;
        csr_rdata[7]     = st_mpie_q;
        csr_rdata[3]     = st_mie_q;
      end
      A_MIE:      csr_rdata = mie_q;
      A_MIP:      csr_rdata = mip;
      A_MTVEC:    csr_rdata = {tvec_base_q, 1'b0, tvec_mode_q};
      A_MSCRATCH: csr_rdata = mscratch_q;
      A_MEPC:     csr_rdata = mepc_q;
      A_MCAUSE:   csr_rdata = mcause_q;
      A_MTVAL:    csr_rdata = mtval_q;
      default:    csr_hit = 1'b0;
    endcase
  end

  assign flush_if.flush_req = (state_q == S_REQ);
  assign flush_if.flush_pc  = fpc_q;
  assign trap_busy          = (state_q == S_REQ);

endmodule

// File: tb/tb_core_ex_trap_ctrl.sv
// Scoreboard bench for core_ex_trap_ctrl: expected redirect targets are
// queued at stimulus time and matched when flush_req rises.
module tb_core_ex_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmt_valid;
  logic [31:0] cmt_pc;
  logic [31:0] cmt_instr;
  logic        ecall, ebreak, illegal, ldm, stm, mret;
  logic [31:0] badaddr;
  logic [2:0]  irq;
  logic [1:0]  plat;
  logic [0:0]  plat2;
  logic        wr_en;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata, rdata2;
  logic        hit, hit2;
  logic        busy, busy2;

  core_ex_trap_ctrl_if #(.PC_WIDTH(32)) fif ();
  core_ex_trap_ctrl_if #(.PC_WIDTH(32)) fif2 ();

  assign fif2.flush_ack = 1'b1;

  always #5 clk = ~clk;

  core_ex_trap_ctrl #(
    .NUM_PLAT_IRQ(2),
    .VECTORED_EN(1'b1),
    .MTVEC_RESET(32'h100)
  ) dut (
    .clk(clk), .rst(rst),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .cmt_instr(cmt_instr),
    .excp_ecall(ecall), .excp_ebreak(ebreak),
    .excp_illegal(illegal),
    .excp_ld_misalign(ldm), .excp_st_misalign(stm),
    .excp_mret(mret), .excp_badaddr(badaddr),
    .irq_pending(irq), .plat_irq_pending(plat),
    .csr_wr_en(wr_en), .csr_addr(addr),
    .csr_wdata(wdata), .csr_rdata(rdata),
    .csr_hit(hit), .flush_if(fif),
    .trap_busy(busy)
  );

  core_ex_trap_ctrl #(
    .NUM_PLAT_IRQ(0),
    .VECTORED_EN(1'b0)
  ) dut_nv (
    .clk(clk), .rst(rst),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .cmt_instr(cmt_instr),
    .excp_ecall(ecall), .excp_ebreak(ebreak),
    .excp_illegal(illegal),
    .excp_ld_misalign(ldm), .excp_st_misalign(stm),
    .excp_mret(mret), .excp_badaddr(badaddr),
    .irq_pending(irq), .plat_irq_pending(plat2),
    .csr_wr_en(wr_en), .csr_addr(addr),
    .csr_wdata(wdata), .csr_rdata(rdata2),
    .csr_hit(hit2), .flush_if(fif2),
    .trap_busy(busy2)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [11:0] a,
                        input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic csr_wr(input logic [11:0] a,
                        input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic clr();
    cmt_valid = 1'b0;
    ecall     = 1'b0;
    ebreak    = 1'b0;
    illegal   = 1'b0;
    ldm       = 1'b0;
    stm       = 1'b0;
    mret      = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc,
                        input logic [31:0] exp_pc);
    cmt_valid = 1'b1;
    cmt_pc    = pc;
    exp_q.push_back(exp_pc);
    tick();
    clr();
  endtask

  task automatic ack();
    fif.flush_ack = 1'b1;
    tick();
    fif.flush_ack = 1'b0;
    chk("ack_idle", {31'b0, fif.flush_req}, 32'h0);
  endtask

  // Redirect monitor: every rising flush_req must match the queued target.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (fif.flush_req && !prev) begin
        chk("flush_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) chk("flush_pc", fif.flush_pc, exp_q.pop_front());
      end
      prev = fif.flush_req;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clr();
    cmt_pc = '0;
    cmt_instr = '0;
    badaddr = '0;
    irq = '0;
    plat = '0;
    plat2 = '0;
    wr_en = 1'b0;
    addr = '0;
    wdata = '0;
    fif.flush_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_freq", {31'b0, fif.flush_req}, 32'h0);
    chk("rst_fpc", fif.flush_pc, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rd_chk("rst_mstatus", 12'h300, 32'h1800);
    chk("hit_mstatus", {31'b0, hit}, 32'h1);
    rd_chk("rst_mtvec", 12'h305, 32'h100);
    rd_chk("rst_mepc", 12'h341, 32'h0);
    addr = 12'h7C0;
    #1;
    chk("hit_none", {31'b0, hit}, 32'h0);

    ecall = 1'b1;
    commit(32'h80, 32'h100);
    rd_chk("ecall_mepc", 12'h341, 32'h80);
    rd_chk("ecall_mcause", 12'h342, 32'hB);
    rd_chk("ecall_mtval", 12'h343, 32'h0);
    rd_chk("ecall_mstatus", 12'h300, 32'h1800);
    chk("ecall_busy", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_freq", {31'b0, fif.flush_req}, 32'h1);
      chk("hold_fpc", fif.flush_pc, 32'h100);
    end
    ack();

    illegal = 1'b1;
    ecall = 1'b1;
    cmt_instr = 32'hFFFF_FFFF;
    wr_en = 1'b1;
    addr = 12'h340;
    wdata = 32'h1234;
    commit(32'h84, 32'h100);
    wr_en = 1'b0;
    rd_chk("ill_mcause", 12'h342, 32'h2);
    rd_chk("ill_mtval", 12'h343, 32'hFFFF_FFFF);
    rd_chk("ill_wr_drop", 12'h340, 32'h0);
    csr_wr(12'h340, 32'h55);
    rd_chk("req_wr", 12'h340, 32'h55);
    ack();

    csr_wr(12'h305, 32'h201);
    csr_wr(12'h304, 32'h880);
    csr_wr(12'h300, 32'h8);
    rd_chk("mtvec_vec", 12'h305, 32'h201);
    chk("mtvec_novec", rdata2, 32'h200);
    rd_chk("mie_rd", 12'h304, 32'h880);
    irq = 3'b110;
    commit(32'h40, 32'h22C);
    irq = 3'b000;
    rd_chk("mei_mcause", 12'h342, 32'h8000_000B);
    rd_chk("mei_mepc", 12'h341, 32'h40);
    rd_chk("mei_mstatus", 12'h300, 32'h1880);
    ack();
    mret = 1'b1;
    commit(32'h44, 32'h40);
    rd_chk("mret_mstatus", 12'h300, 32'h1888);
    ack();

    csr_wr(12'h300, 32'h0);
    irq = 3'b100;
    cmt_valid = 1'b1;
    tick();
    clr();
    chk("mie0_freq", {31'b0, fif.flush_req}, 32'h0);
    chk("mie0_busy", {31'b0, busy}, 32'h0);
    rd_chk("mip_rd", 12'h344, 32'h800);
    irq = 3'b000;

    csr_wr(12'h304, 32'hFFFF_FFFF);
    rd_chk("mie_mask", 12'h304, 32'h3_0888);
    csr_wr(12'h304, 32'h88);
    csr_wr(12'h300, 32'h8);
    irq = 3'b011;
    commit(32'h48, 32'h20C);
    irq = 3'b000;
    rd_chk("msi_mcause", 12'h342, 32'h8000_0003);
    ack();

    csr_wr(12'h304, 32'h3_0000);
    csr_wr(12'h300, 32'h8);
    plat = 2'b10;
    commit(32'h4C, 32'h244);
    plat = 2'b00;
    rd_chk("plat1_mcause", 12'h342, 32'h8000_0011);
    ack();
    csr_wr(12'h300, 32'h8);
    plat = 2'b11;
    commit(32'h50, 32'h240);
    plat = 2'b00;
    rd_chk("plat0_mcause", 12'h342, 32'h8000_0010);
    ack();

    ldm = 1'b1;
    stm = 1'b1;
    badaddr = 32'h1003;
    commit(32'h20, 32'h200);
    rd_chk("ld_mcause", 12'h342, 32'h4);
    rd_chk("ld_mtval", 12'h343, 32'h1003);
    ack();
    stm = 1'b1;
    badaddr = 32'h2002;
    commit(32'h24, 32'h200);
    rd_chk("st_mcause", 12'h342, 32'h6);
    rd_chk("st_mtval", 12'h343, 32'h2002);
    ack();

    ecall = 1'b1;
    commit(32'h300, 32'h200);
    chk("pre_rst_freq", {31'b0, fif.flush_req}, 32'h1);
    rst = 1'b1;
    tick();
    chk("rst_req_freq", {31'b0, fif.flush_req}, 32'h0);
    chk("rst_req_busy", {31'b0, busy}, 32'h0);
    rd_chk("rst_req_mstatus", 12'h300, 32'h1800);
    rd_chk("rst_req_mepc", 12'h341, 32'h0);
    rd_chk("rst_req_mtvec", 12'h305, 32'h100);
    rst = 1'b0;
    tick();

    ebreak = 1'b1;
    ecall = 1'b1;
    commit(32'h10, 32'h100);
    rd_chk("ebrk_mcause", 12'h342, 32'h3);
    rd_chk("ebrk_mtval", 12'h343, 32'h10);
    ack();

    tick();
    tick();
    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
